// File: rtl/sync_data_capture_pkg.sv
// Shared definitions for the burst capture block: state encoding, default
// geometry and the width helper used by the FIFO and the top level.
package sync_data_capture_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_BURST_LEN = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_t;

    // Number of address bits needed to index 'value' entries (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_data_capture_if.sv
// Word stream from the synchroniser into the capture block and the FIFO
// head handshake out of it.
interface sync_data_capture_if #(
    parameter int DATA_W = 16
);
    logic              start_data;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output start_data, in_valid, data_in, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  start_data, in_valid, data_in, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/sync_data_capture_fifo.sv
// Synchronous FIFO with a registered head word; a word pushed into an empty
// FIFO shows up on head_data one cycle later, never combinationally.
module sync_fifo
    import sync_data_capture_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int AW     = clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     rd_ptr_next;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [DATA_W-1:0] head_reg;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        level_next  = level_reg;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            // When the word written this cycle becomes the new head, the RAM
            // still holds the old contents at that address, so forward it.
            if (level_next != '0) begin
                head_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data
                                                                     : mem[rd_ptr_next];
            end
        end
    end

    assign head_data = head_reg;
    assign level     = level_reg;

endmodule

// File: rtl/sync_data_capture.sv
// Burst capture: counts BURST_LEN qualified words after each start pulse,
// queues them in a FIFO and keeps sticky error flags and a burst counter.
module sync_data_capture
    import sync_data_capture_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int BURST_LEN = DEF_BURST_LEN,
    localparam int LW        = clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    sync_data_capture_if.slave   bus,
    output logic                 busy,
    output logic                 burst_done,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 restart_err,
    output logic [7:0]           burst_cnt
);

    localparam logic [7:0] LAST_WORD = 8'(BURST_LEN);

    cap_state_t state_reg;
    cap_state_t state_next;
    logic [7:0] word_cnt_reg;
    logic [7:0] word_cnt_next;
    logic       overflow_reg;
    logic       restart_err_reg;
    logic [7:0] burst_cnt_reg;
    logic       push;
    logic       burst_hit;
    logic       restart;
    logic       drop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        push          = 1'b0;
        burst_hit     = 1'b0;
        restart       = 1'b0;
        if (bus.start_data) begin
            // A start pulse always opens a fresh burst, aborting any open one.
            restart       = (state_reg == ST_CAPTURE);
            push          = bus.in_valid;
            word_cnt_next = bus.in_valid ? 8'd1 : 8'd0;
            state_next    = ST_CAPTURE;
            if (bus.in_valid && (LAST_WORD == 8'd1)) begin
                burst_hit     = 1'b1;
                word_cnt_next = 8'd0;
                state_next    = ST_IDLE;
            end
        end else if ((state_reg == ST_CAPTURE) && bus.in_valid) begin
            push          = 1'b1;
            word_cnt_next = word_cnt_reg + 8'd1;
            if ((word_cnt_reg + 8'd1) == LAST_WORD) begin
                burst_hit     = 1'b1;
                word_cnt_next = 8'd0;
                state_next    = ST_IDLE;
            end
        end
    end

    assign pop  = !fifo_empty && bus.out_ready;
    // A refused word still counts toward the burst; it is only lost.
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            word_cnt_reg    <= 8'd0;
            overflow_reg    <= 1'b0;
            restart_err_reg <= 1'b0;
            burst_cnt_reg   <= 8'd0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr) begin
                overflow_reg <= 1'b0;
            end
            if (restart) begin
                restart_err_reg <= 1'b1;
            end else if (clr) begin
                restart_err_reg <= 1'b0;
            end
            if (burst_hit) begin
                burst_cnt_reg <= clr ? 8'd1 : burst_cnt_reg + 8'd1;
            end else if (clr) begin
                burst_cnt_reg <= 8'd0;
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.data_in),
        .pop       (pop),
        .head_data (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign bus.out_valid = !fifo_empty;
    assign busy          = (state_reg == ST_CAPTURE);
    assign burst_done    = burst_hit;
    assign overflow      = overflow_reg;
    assign restart_err   = restart_err_reg;
    assign burst_cnt     = burst_cnt_reg;

endmodule

// File: doc/sync_data_capture.md
SYNC_DATA_CAPTURE -- requirements
Module: sync_data_capture

Interface
REQ-001 Parameter DATA_W, default 16, width of one synchroniser data word (matches synch top data bus MSB+1).
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-003 Parameter BURST_LEN, default 8, words captured per burst; range 1..255.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start_data  input  1  one-cycle pulse from synch top marking burst start; the word on data_in that cycle is the first word when in_valid=1.
REQ-007 in_valid  input  1  data_in qualifier.
REQ-008 data_in  input  DATA_W  synch top result word.
REQ-009 clr  input  1  synchronous clear of sticky flags and counters; FIFO contents untouched.
REQ-010 out_valid  output  1  FIFO head valid.
REQ-011 out_data  output  DATA_W  FIFO head word.
REQ-012 out_ready  input  1  consumer accepts head; pop occurs when out_valid & out_ready.
REQ-013 busy  output  1  capture FSM in CAPTURE.
REQ-014 burst_done  output  1  one-cycle pulse, last word of a burst accepted or dropped.
REQ-015 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 overflow  output  1  sticky, a word was dropped because the FIFO was full.
REQ-017 restart_err  output  1  sticky, start_data arrived during CAPTURE.
REQ-018 burst_cnt  output  8  completed bursts, wraps 255->0.

Function
REQ-019 FSM states IDLE, CAPTURE; reset state IDLE.
REQ-020 IDLE: in_valid words without start_data are ignored.
REQ-021 IDLE->CAPTURE on start_data; word counter loads 1 if in_valid that cycle (word pushed), else 0.
REQ-022 CAPTURE: each in_valid cycle increments the word counter and offers the word to the FIFO.
REQ-023 When the counter reaches BURST_LEN, that cycle: burst_done=1, burst_cnt+1, FSM->IDLE next cycle; with BURST_LEN=1, start_data+in_valid completes in one cycle, FSM stays IDLE.
REQ-024 start_data in CAPTURE: set restart_err, counter restarts as in REQ-021, no burst_done for the aborted burst; words already pushed remain.
REQ-025 Push accepted when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
REQ-026 Push refused: word dropped, overflow set, word still counts toward BURST_LEN.
REQ-027 Simultaneous push and pop: level unchanged; on empty FIFO no bypass, pushed word appears on out_data next cycle (latency 1).
REQ-028 out_data stable while out_valid=1 and out_ready=0.
REQ-029 Pointers wrap modulo DEPTH; level counts 0..DEPTH inclusive.
REQ-030 clr clears overflow, restart_err, burst_cnt; if clr coincides with a setting event, the set wins.
REQ-031 clr does not change FSM state, word counter or FIFO.

Reset
REQ-032 On rst: FSM IDLE, word counter 0, pointers 0, level 0, out_valid 0, out_data 0, busy 0, burst_done 0, overflow 0, restart_err 0, burst_cnt 0.
REQ-033 rst mid-burst discards the partial burst and all FIFO contents; no burst_done is generated.
REQ-034 FIFO storage array is not reset; only pointers and valid state.

Structure
REQ-035 Shared package holds FSM state encoding, default DATA_W/DEPTH/BURST_LEN and the clog2 helper.
REQ-036 One sub-module sync_fifo (param DATA_W, DEPTH; push/pop/full/empty/level) instantiated once; capture FSM and flags live in sync_data_capture.

Verification
REQ-037 BURST_LEN=8, start_data+8 consecutive in_valid words 1..8, out_ready=1 -> out_data 1..8 in order from cycle after each push, burst_done on word 8, burst_cnt=1.
REQ-038 DEPTH=16, out_ready=0, three bursts of 8 -> level=16, overflow=1, burst_cnt=3, out_data=first word of burst 1.
REQ-039 start_data after 3 words of a burst, then 8 words -> restart_err=1, 11 words in FIFO, one burst_done.
REQ-040 Full FIFO, push and pop same cycle -> push accepted, level stays 16, overflow stays 0.
REQ-041 rst asserted after word 4 of a burst -> all outputs at reset values same cycle; next start_data starts a clean burst.
REQ-042 256 complete bursts -> burst_cnt wraps to 0; clr with pending overflow -> overflow 0 next cycle.
